// File: rtl/trax_move_tx.sv
// Trax move transmitter: renders a 22-bit move as ASCII (column, decimal row, tile) and sends it as UART 8N1.
// Optional build macro TRAX_TX_NEWLINE_EN appends an LF after the tile character.
module trax_move_tx #(
  parameter int unsigned CLKS_PER_BIT   = 434,
  parameter int unsigned MAX_COL_LETTER = 26
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [21:0] move_in,
  input  logic        start_transmit,
  output logic        tx,
  output logic        busy,
  output logic        done,
  output logic        error
);

  localparam int unsigned   BW        = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);

  typedef enum logic [3:0] {
    S_IDLE, S_CHECK, S_CONVERT, S_LOAD, S_START, S_DATA, S_STOP, S_FINISH
  } state_t;

  state_t        state_q, state_d;
  logic [1:0]    tile_q, tile_d;
  logic [9:0]    col_q, col_d;
  logic [25:0]   conv_q, conv_d;
  logic [3:0]    cnt_q, cnt_d;
  logic [7:0]    chr_q [7];
  logic [7:0]    chr_d [7];
  logic [2:0]    nchar_q, nchar_d;
  logic [2:0]    idx_q, idx_d;
  logic [7:0]    shreg_q, shreg_d;
  logic [2:0]    bit_q, bit_d;
  logic [BW-1:0] baud_q, baud_d;
  logic          tx_q, tx_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          error_q, error_d;

  logic [25:0]   dd;
  logic [7:0]    build_chr [7];
  logic [2:0]    build_n;
  logic [2:0]    p;
  int unsigned   ndig;

  // One shift-add-3 step: BCD digits live in conv[25:10], binary row in conv[9:0].
  always_comb begin
    dd = conv_q;
    for (int unsigned k = 0; k < 4; k++) begin
      if (dd[10+4*k +: 4] >= 4'd5) dd[10+4*k +: 4] = dd[10+4*k +: 4] + 4'd3;
    end
  end

  always_comb begin
    build_chr = '{default: '0};
    if (conv_q[25:22] != 4'd0)      ndig = 4;
    else if (conv_q[21:18] != 4'd0) ndig = 3;
    else if (conv_q[17:14] != 4'd0) ndig = 2;
    else                            ndig = 1;
    build_chr[0] = 8'h40 + col_q[7:0];
    p = 3'd1;
    for (int unsigned i = 0; i < 4; i++) begin
      if (ndig > (3 - i)) begin
        build_chr[p] = 8'h30 + {4'h0, conv_q[10+4*(3-i) +: 4]};
        p = p + 3'd1;
      end
    end
    case (tile_q)
      2'b01:   build_chr[p] = 8'h2B;
      2'b10:   build_chr[p] = 8'h2F;
      default: build_chr[p] = 8'h5C;
    endcase
    p = p + 3'd1;
`ifdef TRAX_TX_NEWLINE_EN
    build_chr[p] = 8'h0A;
    p = p + 3'd1;
`endif
    build_n = p;
  end

  always_comb begin
    state_d = state_q;
    tile_d  = tile_q;
    col_d   = col_q;
    conv_d  = conv_q;
    cnt_d   = cnt_q;
    chr_d   = chr_q;
    nchar_d = nchar_q;
    idx_d   = idx_q;
    shreg_d = shreg_q;
    bit_d   = bit_q;
    baud_d  = baud_q;
    tx_d    = tx_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    error_d = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start_transmit) begin
          tile_d  = move_in[21:20];
          col_d   = move_in[19:10];
          conv_d  = {16'h0, move_in[9:0]};
          busy_d  = 1'b1;
          state_d = S_CHECK;
        end
      end
      S_CHECK: begin
        if (tile_q == 2'b00 || col_q > 10'(MAX_COL_LETTER)) begin
          error_d = 1'b1;
          busy_d  = 1'b0;
          state_d = S_IDLE;
        end else begin
          cnt_d   = '0;
          state_d = S_CONVERT;
        end
      end
      S_CONVERT: begin
        conv_d = dd << 1;
        cnt_d  = cnt_q + 4'd1;
        if (cnt_q == 4'd9) state_d = S_LOAD;
      end
      S_LOAD: begin
        chr_d   = build_chr;
        nchar_d = build_n;
        idx_d   = '0;
        shreg_d = build_chr[0];
        baud_d  = '0;
        tx_d    = 1'b0;
        state_d = S_START;
      end
      S_START: begin
        if (baud_q == BAUD_LAST) begin
          baud_d  = '0;
          bit_d   = '0;
          tx_d    = shreg_q[0];
          shreg_d = shreg_q >> 1;
          state_d = S_DATA;
        end else baud_d = baud_q + BW'(1);
      end
      S_DATA: begin
        if (baud_q == BAUD_LAST) begin
          baud_d = '0;
          if (bit_q == 3'd7) begin
            tx_d    = 1'b1;
            state_d = S_STOP;
          end else begin
            tx_d    = shreg_q[0];
            shreg_d = shreg_q >> 1;
            bit_d   = bit_q + 3'd1;
          end
        end else baud_d = baud_q + BW'(1);
      end
      S_STOP: begin
        // Later characters load straight from STOP so the next start bit follows with no gap.
        if (baud_q == BAUD_LAST) begin
          baud_d = '0;
          if (idx_q + 3'd1 == nchar_q) begin
            done_d  = 1'b1;
            busy_d  = 1'b0;
            state_d = S_FINISH;
          end else begin
            idx_d   = idx_q + 3'd1;
            shreg_d = chr_q[idx_q + 3'd1];
            tx_d    = 1'b0;
            state_d = S_START;
          end
        end else baud_d = baud_q + BW'(1);
      end
      S_FINISH: state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      tile_q  <= '0;
      col_q   <= '0;
      conv_q  <= '0;
      cnt_q   <= '0;
      chr_q   <= '{default: '0};
      nchar_q <= '0;
      idx_q   <= '0;
      shreg_q <= '0;
      bit_q   <= '0;
      baud_q  <= '0;
      tx_q    <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      error_q <= 1'b0;
    end else begin
      state_q <= state_d;
      tile_q  <= tile_d;
      col_q   <= col_d;
      conv_q  <= conv_d;
      cnt_q   <= cnt_d;
      chr_q   <= chr_d;
      nchar_q <= nchar_d;
      idx_q   <= idx_d;
      shreg_q <= shreg_d;
      bit_q   <= bit_d;
      baud_q  <= baud_d;
      tx_q    <= tx_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      error_q <= error_d;
    end
  end

  assign tx    = tx_q;
  assign busy  = busy_q;
  assign done  = done_q;
  assign error = error_q;

endmodule
